// File: rtl/booth_operand_sequencer.sv
// booth_operand_sequencer: FIFO-buffered operand issue and result capture around the booth_multiplier core
//   clock/reset           : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     : operand pair input (in_word1 multiplicand, in_word2 multiplier)
//   mul_word1/2, mul_start: operands and one-cycle start pulse to the core
//   mul_ready/mul_product : core status and product
//   out_valid/out_ready   : result handshake (out_product, out_error)
//   pending               : FIFO occupancy
//   optional BOOTH_SEQ_TIMEOUT_EN: watchdog that aborts a stuck job with out_error=1
module booth_operand_sequencer #(
  parameter int l_word = 4,
  parameter int fifo_depth = 4,
  parameter int timeout_cycles = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [l_word-1:0]          in_word1,
  input  logic [l_word-1:0]          in_word2,
  output logic [l_word-1:0]          mul_word1,
  output logic [l_word-1:0]          mul_word2,
  output logic                       mul_start,
  input  logic                       mul_ready,
  input  logic [2*l_word-1:0]        mul_product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*l_word-1:0]        out_product,
  output logic                       out_error,
  output logic [$clog2(fifo_depth):0] pending
);
  localparam int AW = $clog2(fifo_depth);
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("fifo_depth must be a power of two >= 2");
  end
  if (timeout_cycles < 1) begin : g_bad_timeout
    $error("timeout_cycles must be >= 1");
  end
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_HOLD} state_t;
  state_t state_q, state_d;
  logic [l_word-1:0] mem1 [fifo_depth];
  logic [l_word-1:0] mem2 [fifo_depth];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] pend_q;
  logic [l_word-1:0] w1_q, w1_d, w2_q, w2_d, head1, head2;
  logic [2*l_word-1:0] prod_q, prod_d;
  logic err_q, err_d;
  logic full, pop, push, waiting, to;
  assign full = pend_q == (AW+1)'(fifo_depth);
  assign pop = state_q == S_IDLE && pend_q != '0;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign in_ready = !full || pop;
  assign push = in_valid && in_ready;
  assign head1 = mem1[rd_q];
  assign head2 = mem2[rd_q];
  assign waiting = state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE;
  assign mul_start = state_q == S_ISSUE;
  assign out_valid = state_q == S_HOLD;
  assign mul_word1 = w1_q;
  assign mul_word2 = w2_q;
  assign out_product = prod_q;
  assign pending = pend_q;
`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tcnt_q;
  // fires on the timeout_cycles-th wait cycle
  assign to = waiting && tcnt_q == TW'(timeout_cycles - 1);
  assign out_error = err_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) tcnt_q <= '0;
    else tcnt_q <= state_q == S_ISSUE ? '0 : waiting ? tcnt_q + TW'(1) : tcnt_q;
`else
  assign to = 1'b0;
  assign out_error = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    w1_d = w1_q;
    w2_d = w2_q;
    prod_d = prod_q;
    err_d = err_q;
    case (state_q)
      S_IDLE:
        if (pop) begin
          // the core never drops ready on a zero operand, so bypass it
          if (head1 == '0 || head2 == '0) begin
            prod_d = '0;
            state_d = S_HOLD;
          end else begin
            w1_d = head1;
            w2_d = head2;
            state_d = S_ISSUE;
          end
        end
      S_ISSUE: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY:
        if (to) begin
          prod_d = '0;
          err_d = 1'b1;
          state_d = S_HOLD;
        end else if (!mul_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE:
        if (mul_ready) begin
          prod_d = mul_product;
          state_d = S_HOLD;
        end else if (to) begin
          prod_d = '0;
          err_d = 1'b1;
          state_d = S_HOLD;
        end
      S_HOLD:
        if (out_ready) begin
          err_d = 1'b0;
          state_d = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      wr_q <= '0;
      rd_q <= '0;
      pend_q <= '0;
      w1_q <= '0;
      w2_q <= '0;
      prod_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= push ? wr_q + AW'(1) : wr_q;
      rd_q <= pop ? rd_q + AW'(1) : rd_q;
      pend_q <= pend_q + (AW+1)'(push) - (AW+1)'(pop);
      w1_q <= w1_d;
      w2_q <= w2_d;
      prod_q <= prod_d;
      err_q <= err_d;
    end
  always_ff @(posedge clock)
    if (push) begin
      mem1[wr_q] <= in_word1;
      mem2[wr_q] <= in_word2;
    end
endmodule

// File: tb/tb_booth_operand_sequencer.sv
// tb_booth_operand_sequencer: scoreboard bench with a behavioural booth core model
module tb_booth_operand_sequencer;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 0, mul_ready, mul_start, out_valid, out_error, in_ready;
  logic [3:0] in_word1 = 0, in_word2 = 0, mul_word1, mul_word2;
  logic [7:0] mul_product, out_product;
  logic [2:0] pending;
  logic stall = 0;
  int busy, starts = 0, total = 0, bad = 0;
  logic [7:0] q[$];

  booth_operand_sequencer #(.l_word(4), .fifo_depth(4), .timeout_cycles(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_word1(in_word1), .in_word2(in_word2), .mul_word1(mul_word1), .mul_word2(mul_word2),
    .mul_start(mul_start), .mul_ready(mul_ready), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_error(out_error), .pending(pending));

  always #5 clock = ~clock;

  function automatic logic [7:0] smul(logic signed [3:0] a, logic signed [3:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[7:0];
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clock or posedge reset)
    if (reset) begin
      mul_ready <= 1'b1;
      busy <= 0;
      mul_product <= '0;
    end else if (mul_start) begin
      starts <= starts + 1;
      mul_ready <= 1'b0;
      busy <= 3;
      mul_product <= smul(mul_word1, mul_word2);
    end else if (!mul_ready && !stall) begin
      if (busy == 0) mul_ready <= 1'b1;
      else busy <= busy - 1;
    end

  always @(negedge clock)
    if (!reset && !stall) begin
      if (in_valid && in_ready) q.push_back(smul(in_word1, in_word2));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("extra_result", 1, 0);
        else begin
          chk("product", out_product, q.pop_front());
          chk("error", out_error, 0);
        end
      end
    end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(logic [3:0] a, logic [3:0] b);
    in_valid = 1;
    in_word1 = a;
    in_word2 = b;
    tick();
    in_valid = 0;
  endtask

  task automatic drain(int max);
    int k = 0;
    while ((q.size() != 0 || pending != 0 || out_valid) && k < max) begin
      tick();
      k++;
    end
    chk("drain_timeout", k >= max, 0);
  endtask

  initial begin
    int s0, k;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", out_product, 0);
    chk("rst_error", out_error, 0);
    chk("rst_pending", pending, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_words", {mul_word1, mul_word2}, 0);
    tick(2);
    reset = 0;
    tick();
    out_ready = 1;
    s0 = starts;
    push(4'd3, 4'd2);
    drain(60);
    chk("one_start", starts - s0, 1);
    chk("pending_zero", pending, 0);
    push(4'hD, 4'h5);
    push(4'h2, 4'hC);
    drain(80);
    s0 = starts;
    push(4'h0, 4'h7);
    push(4'h5, 4'h0);
    push(4'h2, 4'h3);
    drain(80);
    chk("zero_bypass_starts", starts - s0, 1);
    out_ready = 0;
    push(1, 2);
    push(1, 3);
    push(1, 4);
    push(1, 5);
    push(1, 6);
    tick(20);
    chk("full_pending", pending, 4);
    chk("full_in_ready", in_ready, 0);
    push(1, 7);
    chk("ignored_push", pending, 4);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("pop_in_ready", in_ready, 1);
    push(2, 7);
    chk("push_pop_full", pending, 4);
    out_ready = 1;
    drain(300);
    push(3, 2);
    push(4, 4);
    push(5, 5);
    k = 0;
    while (mul_ready && k < 40) begin
      tick();
      k++;
    end
    chk("core_busy_timeout", k >= 40, 0);
    tick();
    chk("mid_pending", pending, 2);
    reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_start", mul_start, 0);
    q.delete();
    tick();
    reset = 0;
    tick();
    push(1, 1);
    drain(60);
    stall = 1;
    push(3, 3);
`ifdef BOOTH_SEQ_TIMEOUT_EN
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk("to_valid", out_valid, 1);
    chk("to_error", out_error, 1);
    chk("to_product", out_product, 0);
    tick();
    chk("to_error_clear", out_error, 0);
    chk("to_valid_clear", out_valid, 0);
`else
    tick(40);
    chk("no_to_valid", out_valid, 0);
`endif
    stall = 0;
    reset = 1;
    tick();
    reset = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_operand_sequencer.md
Name: booth_operand_sequencer

Overview:
- Upstream/downstream wrapper stage for the booth_multiplier core.
- Buffers signed operand pairs in a small FIFO and issues them one at a time through the core's start/ready interface.
- Captures each finished product and presents it on a valid/ready output port.
- Bypasses the core for zero operands, because the core flushes and stays idle on that case without ever dropping ready.

Parameters:
- l_word, 4: operand width in bits (two's complement); product is 2*l_word bits.
- fifo_depth, 4: operand FIFO entries; must be a power of two, >= 2.
- timeout_cycles, 64: watchdog limit in clocks; used only when the optional feature is compiled in.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full.
- in_word1  in  l_word  multiplicand.
- in_word2  in  l_word  multiplier.
- mul_word1  out  l_word  to core word1.
- mul_word2  out  l_word  to core word2.
- mul_start  out  1  to core start; one-cycle pulse.
- mul_ready  in  1  from core ready.
- mul_product  in  2*l_word  from core product.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_product  out  2*l_word  result.
- out_error  out  1  result invalid (watchdog); constant 0 when the optional feature is not compiled in.
- pending  out  clog2(fifo_depth)+1  FIFO occupancy.

Behaviour:
- Reset values: in_ready=1, mul_start=0, mul_word1=0, mul_word2=0, out_valid=0, out_product=0, out_error=0, pending=0. FIFO pointers, state and watchdog counter are all cleared.
- FIFO push: in_valid && in_ready at a rising edge.
  - Push is allowed while full only if a pop happens in the same cycle; in that case occupancy is unchanged.
  - Pointers wrap modulo fifo_depth.
- Pop: the FIFO pops when the FSM leaves S_IDLE with a job.
- States: S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_HOLD.
- S_IDLE: if FIFO is not empty and out_valid=0, pop the head.
  - Either operand zero: load out_product=0, go to S_HOLD. The core is not started.
  - Otherwise: drive mul_word1/mul_word2 with the head, go to S_ISSUE.
  - mul_word1/mul_word2 are held stable until S_WAIT_DONE exits.
- S_ISSUE: mul_start=1 for exactly this cycle. Then S_WAIT_BUSY.
- S_WAIT_BUSY: wait for mul_ready=0 (core has loaded), then S_WAIT_DONE.
  - If mul_ready was never high when entering S_ISSUE, the job still proceeds; the start pulse is not repeated.
- S_WAIT_DONE: on mul_ready=1, capture out_product=mul_product, go to S_HOLD.
- S_HOLD: out_valid=1.
  - out_product/out_error stay stable until out_valid && out_ready.
  - The handshake cycle clears out_valid and returns to S_IDLE.
  - Minimum job spacing is 1 idle cycle between results.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- Empty FIFO in S_IDLE: remain idle, mul_start=0.
- Reset mid-operation: everything returns to reset values immediately. The in-flight job and FIFO contents are discarded. The core is reset separately by the same reset.
- Result ordering is strictly FIFO order, including bypassed zero jobs.

Optional Feature:
- Macro: BOOTH_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to S_ISSUE and increments each cycle in S_WAIT_BUSY and S_WAIT_DONE.
  - When the count reaches timeout_cycles, the sequencer sets out_product=0 and out_error=1, and goes to S_HOLD.
  - out_error clears when that result is accepted.
- Without the macro: no counter exists, out_error is tied to 0, and the waits are unbounded.

Test Plan:
- Push (3,2) with l_word=4, behavioural core model -> one mul_start pulse; out_valid with out_product=8'h06; pending returns to 0.
- Push (-3,5) i.e. (4'hD,4'h5) -> out_product=8'hF1 (-15); word2 negative (2,-4) -> 8'hF8.
- Push (0,7) then (5,0) -> no mul_start; two results of 8'h00, each out_valid in order; a third push (2,3) after them -> 8'h06 in order.
- Fill FIFO with 4 pairs, hold out_ready=0 -> in_ready=0 when pending=4; a 5th push is ignored. Simultaneous push/pop when full -> pending stays 4. Release out_ready -> 4 results in push order.
- Assert reset during S_WAIT_DONE with 2 queued -> out_valid=0, pending=0, mul_start=0 the same cycle; a later push (1,1) -> 8'h01.
- With BOOTH_SEQ_TIMEOUT_EN and timeout_cycles=8, core model holds mul_ready=0 -> after 8 wait cycles, out_valid=1, out_error=1, out_product=0. Without the macro, the same stimulus leaves out_valid=0 indefinitely.
